// File: rtl/uart_cmd_parser.sv
// Unloads 18-bit UART command packets, checks odd parity, drives regfile writes/reads and builds replies.
// Packet-ready to reg_we is 4 cycles; replies wait for tx_busy low, and new packets are only taken from IDLE.
module uart_cmd_parser #(
  parameter int NUMREGS     = 9,
  parameter bit ECHO_WRITES = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] rx_data,
  input  logic        rx_empty,
  output logic        uld_rx_data,
  input  logic        tx_busy,
  output logic [17:0] tx_data,
  output logic        ld_tx_data,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  input  logic [7:0]  reg_rdata,
  output logic [7:0]  parity_err_cnt,
  output logic        addr_err,
  output logic        busy
);

  localparam logic [8:0] NUMREGS_W = 9'(NUMREGS);

  typedef enum logic [2:0] {
    IDLE, UNLOAD, CAPTURE, DECODE, EXEC, WAIT_TX, LOAD_TX
  } state_t;

  state_t      state, state_nxt;
  logic [17:0] pkt;
  logic [7:0]  pkt_addr;
  logic [7:0]  pkt_data;
  logic        pkt_wrb;
  logic        pkt_par_ok;
  logic        addr_ok;
  logic        send_reply;
  logic [7:0]  reply_dat;
  logic [16:0] reply_body;

  assign pkt_addr   = pkt[16:9];
  assign pkt_data   = pkt[8:1];
  assign pkt_wrb    = pkt[0];
  assign pkt_par_ok = ^pkt;
  assign addr_ok    = {1'b0, pkt_addr} < NUMREGS_W;
  assign send_reply = pkt_wrb | ECHO_WRITES;
  // Out-of-range reads reply with zero rather than whatever the regfile returns.
  assign reply_dat  = pkt_wrb ? (addr_ok ? reg_rdata : 8'h00) : pkt_data;
  assign reply_body = {pkt_addr, reply_dat, pkt_wrb};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    uld_rx_data = 1'b0;
    reg_we      = 1'b0;
    ld_tx_data  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!rx_empty) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        uld_rx_data = 1'b1;
        state_nxt   = CAPTURE;
      end
      CAPTURE: state_nxt = DECODE;
      DECODE:  state_nxt = pkt_par_ok ? EXEC : IDLE;
      EXEC: begin
        reg_we    = ~pkt_wrb & addr_ok;
        state_nxt = send_reply ? WAIT_TX : IDLE;
      end
      WAIT_TX: if (!tx_busy) state_nxt = LOAD_TX;
      LOAD_TX: begin
        ld_tx_data = 1'b1;
        if (tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt            <= '0;
      reg_addr       <= '0;
      reg_wdata      <= '0;
      tx_data        <= '0;
      parity_err_cnt <= '0;
      addr_err       <= 1'b0;
    end else begin
      case (state)
        CAPTURE: pkt <= rx_data;
        DECODE: begin
          if (!pkt_par_ok) begin
            if (parity_err_cnt != 8'hFF) parity_err_cnt <= parity_err_cnt + 8'd1;
          end else begin
            reg_addr  <= pkt_addr;
            reg_wdata <= pkt_data;
          end
        end
        EXEC: begin
          if (!addr_ok) addr_err <= 1'b1;
          // tx_data only changes when a new reply is built, so it holds through WAIT_TX/LOAD_TX.
          if (send_reply) tx_data <= {~^reply_body, reply_body};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser with a packet-level reference model and uart_rx/uart_tx/regfile stand-ins.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [17:0] rx_data = '0;
  logic        rx_empty = 1'b1;
  logic        uld_rx_data;
  logic        tx_busy = 1'b0;
  logic [17:0] tx_data;
  logic        ld_tx_data;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;
  logic [7:0]  parity_err_cnt;
  logic        addr_err;
  logic        busy;

  uart_cmd_parser #(.NUMREGS(9), .ECHO_WRITES(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_empty(rx_empty),
    .uld_rx_data(uld_rx_data), .tx_busy(tx_busy), .tx_data(tx_data),
    .ld_tx_data(ld_tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rdata(reg_rdata), .parity_err_cnt(parity_err_cnt),
    .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bench-side regfile (written by DUT) and the model's own view of register contents.
  logic [7:0] regs_hw  [0:8];
  logic [7:0] mdl_regs [0:8];
  always_comb begin
    reg_rdata = 8'hEE;
    if (reg_addr < 8'd9) reg_rdata = regs_hw[reg_addr[3:0]];
  end

  logic [17:0] rx_q[$];
  logic [17:0] exp_q[$];
  int          gap = 0;
  int          cyc = 0;
  int          exp_we_cyc = -10;
  logic [7:0]  exp_we_addr, exp_we_dat;
  logic [7:0]  m_cnt = 8'd0;
  logic        m_aerr = 1'b0;
  int          tx_cnt = 0;
  int          tx_max = 3;
  bit          force_busy = 1'b0;
  bit          ld_prev = 1'b0;
  logic [17:0] last_tx = '0;
  int          tx_accepts = 0;
  int          we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] mk(input logic [7:0] a, input logic [7:0] d,
                                     input logic w, input bit good);
    logic [16:0] b;
    logic        p;
    b = {a, d, w};
    p = ($countones(b) % 2 == 0);
    if (!good) p = ~p;
    return {p, b};
  endfunction

  // Packet-level reference: what one unloaded packet must cause.
  task automatic model_packet(input logic [17:0] p);
    logic [7:0] a, d;
    logic       w;
    bit         in_range;
    if ($countones(p) % 2 == 0) begin
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end else begin
      a = p[16:9];
      d = p[8:1];
      w = p[0];
      in_range = (a < 9);
      if (!in_range) m_aerr = 1'b1;
      if (!w) begin
        if (in_range) begin
          exp_we_cyc  = cyc + 3;
          exp_we_addr = a;
          exp_we_dat  = d;
          mdl_regs[a[3:0]] = d;
        end
        exp_q.push_back(mk(a, d, 1'b0, 1'b1));
      end else begin
        exp_q.push_back(mk(a, in_range ? mdl_regs[a[3:0]] : 8'h00, 1'b1, 1'b1));
      end
    end
  endtask

  // Per-cycle compare plus uart_rx / uart_tx stand-ins, all sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        check("uld_we_overlap", {31'b0, uld_rx_data & reg_we}, 0);
        if (uld_rx_data) begin
          check("busy_at_unload", {31'b0, busy}, 1);
          check("parity_err_cnt", {24'b0, parity_err_cnt}, {24'b0, m_cnt});
          check("addr_err", {31'b0, addr_err}, {31'b0, m_aerr});
          model_packet(rx_data);
          rx_empty = 1'b1;
          gap = 4 + $urandom_range(0, 3);
        end
        check("reg_we", {31'b0, reg_we}, {31'b0, cyc == exp_we_cyc});
        if (reg_we) begin
          check("reg_addr", {24'b0, reg_addr}, {24'b0, exp_we_addr});
          check("reg_wdata", {24'b0, reg_wdata}, {24'b0, exp_we_dat});
          if (reg_addr < 8'd9) regs_hw[reg_addr[3:0]] = reg_wdata;
          we_count++;
        end
        if (tx_cnt > 0) tx_cnt--;
        if (ld_tx_data) begin
          if (!ld_prev) check("ld_rise_while_busy", {31'b0, tx_busy}, 0);
          if (tx_busy) begin
            check("tx_data_hold", {14'b0, tx_data}, {14'b0, last_tx});
          end else if (exp_q.size() == 0) begin
            check("unexpected_ld_tx_data", 1, 0);
          end else begin
            check("tx_data", {14'b0, tx_data}, {14'b0, exp_q[0]});
            last_tx = tx_data;
            tx_accepts++;
            void'(exp_q.pop_front());
            tx_cnt = $urandom_range(1, tx_max);
          end
        end
        ld_prev = ld_tx_data;
        tx_busy = force_busy || (tx_cnt > 0);
        if (gap > 0) gap--;
        else if (rx_empty && rx_q.size() > 0) begin
          rx_data  = rx_q.pop_front();
          rx_empty = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(rx_q.size() == 0 && rx_empty && gap == 0 && !busy && exp_q.size() == 0) && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, {31'b0, n < limit}, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_uld"}, {31'b0, uld_rx_data}, 0);
    check({tag, "_tx_data"}, {14'b0, tx_data}, 0);
    check({tag, "_ld_tx"}, {31'b0, ld_tx_data}, 0);
    check({tag, "_reg_addr"}, {24'b0, reg_addr}, 0);
    check({tag, "_reg_wdata"}, {24'b0, reg_wdata}, 0);
    check({tag, "_reg_we"}, {31'b0, reg_we}, 0);
    check({tag, "_perr"}, {24'b0, parity_err_cnt}, 0);
    check({tag, "_aerr"}, {31'b0, addr_err}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, wec;
    for (int i = 0; i < 9; i++) begin
      regs_hw[i]  = 8'(i * 17);
      mdl_regs[i] = 8'(i * 17);
    end
    #1 reset_n = 1'b0;
    #3 check_all_zero("reset");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Directed packets with literal expectations.
    rx_q.push_back(18'h2074A);
    wait_idle("wr_done", 200);
    check("wr_reply", {14'b0, last_tx}, 32'h2074A);
    check("wr_regfile", {24'b0, regs_hw[3]}, 32'hA5);
    check("wr_count", we_count, 1);

    rx_q.push_back(18'h00601);
    wait_idle("rd_done", 200);
    check("rd_reply", {14'b0, last_tx}, 32'h0074B);
    check("rd_no_we", we_count, 1);

    acc = tx_accepts;
    rx_q.push_back(18'h0074A);
    wait_idle("perr_done", 200);
    check("perr_cnt_one", {24'b0, parity_err_cnt}, 1);
    check("perr_no_reply", tx_accepts, acc);
    check("perr_no_we", we_count, 1);

    rx_q.push_back(18'h01201);
    wait_idle("oor_rd_done", 200);
    check("oor_rd_reply", {14'b0, last_tx}, 32'h01201);
    check("oor_addr_err", {31'b0, addr_err}, 1);
    rx_q.push_back(18'h21222);
    wait_idle("oor_wr_done", 200);
    check("oor_wr_no_we", we_count, 1);
    check("oor_wr_reply", {14'b0, last_tx}, 32'h21222);

    // Reply held off by a long tx_busy.
    force_busy = 1'b1;
    tx_busy = 1'b1;
    acc = tx_accepts;
    rx_q.push_back(18'h00601);
    repeat (50) @(negedge clk);
    #1;
    check("busy_hold_ld", {31'b0, ld_tx_data}, 0);
    check("busy_hold_accepts", tx_accepts, acc);
    check("busy_hold_busy", {31'b0, busy}, 1);
    force_busy = 1'b0;
    wait_idle("busy_release", 200);
    check("busy_reply", {14'b0, last_tx}, 32'h0074B);

    // Two queued reads reply in order.
    rx_q.push_back(mk(8'd3, 8'h5A, 1'b1, 1'b1));
    rx_q.push_back(mk(8'd0, 8'h00, 1'b1, 1'b1));
    wait_idle("two_reads", 400);
    check("two_reads_last", {14'b0, last_tx}, {14'b0, mk(8'd0, 8'h00, 1'b1, 1'b1)});

    // Randomized traffic.
    tx_max = 20;
    for (int i = 0; i < 150; i++) begin
      rx_q.push_back(mk(8'($urandom_range(0, 11)), 8'($urandom), 1'($urandom), $urandom_range(0, 99) < 85));
    end
    wait_idle("random_done", 20000);
    check("random_perr", {24'b0, parity_err_cnt}, {24'b0, m_cnt});
    check("random_aerr", {31'b0, addr_err}, {31'b0, m_aerr});

    // Saturation of the parity error counter.
    for (int i = 0; i < 300; i++) begin
      rx_q.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom), 1'b0));
    end
    wait_idle("sat_done", 20000);
    check("perr_saturated", {24'b0, parity_err_cnt}, 32'hFF);
    check("model_saturated", {24'b0, m_cnt}, 32'hFF);

    // Reset while the reply is waiting for uart_tx.
    force_busy = 1'b1;
    tx_busy = 1'b1;
    rx_q.push_back(18'h00601);
    repeat (12) @(negedge clk);
    #1 check("pre_reset_busy", {31'b0, busy}, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midop_reset");
    exp_q.delete();
    rx_q.delete();
    rx_empty   = 1'b1;
    gap        = 0;
    exp_we_cyc = -10;
    m_cnt      = 8'd0;
    m_aerr     = 1'b0;
    ld_prev    = 1'b0;
    tx_cnt     = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    force_busy = 1'b0;
    acc = tx_accepts;
    wec = we_count;
    repeat (30) @(negedge clk);
    #1;
    check("post_reset_busy", {31'b0, busy}, 0);
    check("post_reset_no_reply", tx_accepts, acc);
    check("post_reset_no_we", we_count, wec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits inside digital_core between the chip-side uart_rx and the config regfile / uart_tx.
- Unloads each received 18-bit UART packet and checks its parity.
- Valid writes go to the regfile. Valid reads, and writes when echo is enabled, produce a reply packet that is loaded into uart_tx.
- Packet format: bit 17 parity, 16:9 addr, 8:1 data, 0 wrb (0=write, 1=read). Parity is odd over all 18 bits.

Parameters:
- NUMREGS, 9, number of implemented registers; valid addresses are 0..NUMREGS-1.
- ECHO_WRITES, 1, 1 = send a reply packet after each accepted write.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_data  input  18  packet from uart_rx
- rx_empty  input  1  low = uart_rx holds an unread packet
- uld_rx_data  output  1  one-cycle unload strobe to uart_rx
- tx_busy  input  1  high while uart_tx is shifting
- tx_data  output  18  reply packet to uart_tx
- ld_tx_data  output  1  load request to uart_tx
- reg_addr  output  8  regfile address
- reg_wdata  output  8  regfile write data
- reg_we  output  1  one-cycle regfile write strobe
- reg_rdata  input  8  regfile read data, combinational on reg_addr
- parity_err_cnt  output  8  count of dropped bad-parity packets, saturating
- addr_err  output  1  sticky flag: out-of-range access seen
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE. Reset asserted mid-operation aborts immediately. A partially handled packet is lost; no reg_we or ld_tx_data occurs after reset release until a new packet arrives.
- States: IDLE, UNLOAD, CAPTURE, DECODE, EXEC, WAIT_TX, LOAD_TX.
- IDLE:
  - Go to UNLOAD when rx_empty==0.
- UNLOAD:
  - uld_rx_data=1 for exactly one cycle; go to CAPTURE.
- CAPTURE:
  - uld_rx_data=0; register rx_data into an internal packet register; go to DECODE.
- DECODE:
  - Compute XOR of all 18 captured bits.
  - If the XOR is 0 (parity error): increment parity_err_cnt (saturate at 0xFF, no wrap), drop the packet, go to IDLE.
  - Otherwise: reg_addr=captured addr, reg_wdata=captured data; go to EXEC.
- EXEC, write (wrb=0):
  - If addr<NUMREGS: reg_we=1 for one cycle.
  - If addr>=NUMREGS: no reg_we; set addr_err.
  - Reply data = captured data. If ECHO_WRITES==0, go straight to IDLE.
- EXEC, read (wrb=1):
  - Sample reg_rdata. If addr>=NUMREGS, reply data = 0x00 and set addr_err.
  - The request's data field is ignored.
- Reply construction:
  - tx_data = {p, addr, reply_data, wrb}, with p chosen so the 18 bits have odd parity.
  - Go to WAIT_TX.
- WAIT_TX:
  - Wait while tx_busy==1; go to LOAD_TX when tx_busy==0.
- LOAD_TX:
  - ld_tx_data=1, held until tx_busy is sampled 1; then ld_tx_data=0 and go to IDLE.
  - tx_data stays stable from entry to WAIT_TX until the next reply is built.
- Latency: packet available to reg_we = 4 cycles (IDLE detect, UNLOAD, CAPTURE, DECODE, strobe in EXEC).
- Back-to-back packets: rx_empty is re-examined only in IDLE. A new packet waiting during an earlier reply is processed after return to IDLE; none is lost as long as uart_rx buffers it.
- addr_err clears only on reset.
- reg_we and uld_rx_data are never high in the same cycle.

Test Plan:
- Write: rx_data=0x2074A (addr 0x03, data 0xA5, wrb 0) -> reg_we pulses once with reg_addr=0x03, reg_wdata=0xA5; tx_data=0x2074A; ld_tx_data asserted.
- Readback: rx_data=0x00601 with reg_rdata=0xA5 -> no reg_we; tx_data=0x0074B (parity 0, addr 0x03, data 0xA5, wrb 1).
- Parity error: rx_data=0x0074A -> no reg_we, no ld_tx_data; parity_err_cnt 0->1. After 300 bad packets parity_err_cnt=0xFF.
- Out of range: read rx_data=0x01201 (addr 0x09) -> tx_data=0x01201 (data 0x00); addr_err=1. Write to 0x09 -> no reg_we.
- Busy TX: hold tx_busy=1 for 50 cycles after a read decode -> ld_tx_data stays 0 until tx_busy falls, then asserts with tx_data unchanged. Two queued packets -> two replies in order.
- Reset mid-op: assert reset_n=0 during WAIT_TX -> all outputs 0 the same cycle; after release, busy=0 and no reply is sent.
